// File: rtl/masked_dp_ram.sv
// masked_dp_ram: simple-dual-port RAM with a per-bit write mask, a two-stage registered
// read pipeline and a hardware clear sequencer that runs after every reset.
//
// Ports:
//   clk    - clock, rising-edge active
//   rst    - asynchronous active-high reset; restarts the clear sequence
//   we     - write request (ignored while busy)
//   waddr  - write address
//   wmask  - per-bit write enable, bit i = 1 writes din[i]
//   din    - write data
//   re     - read request (ignored while busy)
//   raddr  - read address
//   dout   - read data, held until the next valid read
//   rvalid - one-cycle pulse: dout was updated by this cycle's edge
//   busy   - clear sequence in progress
module masked_dp_ram #(
   parameter int unsigned          DATA_W    = 8,
   parameter int unsigned          ADDR_W    = 4,
   parameter logic [DATA_W-1:0]    CLEAR_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wmask,
   input  logic [DATA_W-1:0] din,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] dout,
   output logic              rvalid,
   output logic              busy
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   localparam logic ST_CLEAR = 1'b0;
   localparam logic ST_RUN   = 1'b1;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] s1_data_q, s1_data_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              rvalid_q, rvalid_d;

   logic              run;
   logic [DATA_W-1:0] wr_merged;

   assign run       = (state_q == ST_RUN);
   assign wr_merged = (mem[waddr] & ~wmask) | (din & wmask);

   // Clear sequencer: one word per edge, hand over to RUN on the edge that writes the last word.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (!run) begin
         ptr_d = ptr_q + ADDR_W'(1);
         if (ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_d = ST_RUN;
         end
      end
   end

   // Read pipeline. Same-address read-during-write sees the merged word (write-first).
   always_comb begin
      s1_valid_d = run && re;
      s1_data_d  = s1_data_q;
      if (run && re) begin
         if (we && (waddr == raddr)) begin
            s1_data_d = wr_merged;
         end else begin
            s1_data_d = mem[raddr];
         end
      end
      rvalid_d = s1_valid_q;
      dout_d   = s1_valid_q ? s1_data_q : dout_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_CLEAR;
         ptr_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         dout_q     <= '0;
         rvalid_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         dout_q     <= dout_d;
         rvalid_q   <= rvalid_d;
      end
   end

   // Array has no reset; the clear sequencer owns it until RUN.
   always_ff @(posedge clk) begin
      if (!run) begin
         mem[ptr_q] <= CLEAR_VAL;
      end else if (we) begin
         mem[waddr] <= wr_merged;
      end
   end

   assign dout   = dout_q;
   assign rvalid = rvalid_q;
   assign busy   = !run;

endmodule

// File: tb/tb_masked_dp_ram.sv
module tb_masked_dp_ram;

   logic       clk = 1'b0;
   logic       rst;
   logic       we;
   logic [3:0] waddr;
   logic [7:0] wmask;
   logic [7:0] din;
   logic       re;
   logic [3:0] raddr;
   logic [7:0] dout;
   logic       rvalid;
   logic       busy;

   int vectors    = 0;
   int miscompares = 0;

   masked_dp_ram #(
      .DATA_W    (8),
      .ADDR_W    (4),
      .CLEAR_VAL (8'h00)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .we     (we),
      .waddr  (waddr),
      .wmask  (wmask),
      .din    (din),
      .re     (re),
      .raddr  (raddr),
      .dout   (dout),
      .rvalid (rvalid),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
      we = 1'b1; waddr = a; din = d; wmask = m;
      tick();
      we = 1'b0;
   endtask

   // Isolated read: rvalid must pulse exactly on the second edge and dout must hold afterwards.
   task automatic do_read(input string tag, input logic [3:0] a, input logic [7:0] exp);
      re = 1'b1; raddr = a;
      tick();
      re = 1'b0;
      check({tag, "_rv_lat1"}, 8'(rvalid), 8'h00);
      tick();
      check({tag, "_rv"}, 8'(rvalid), 8'h01);
      check({tag, "_dout"}, dout, exp);
      tick();
      check({tag, "_rv_off"}, 8'(rvalid), 8'h00);
      check({tag, "_hold"}, dout, exp);
   endtask

   // Release reset before the next edge and check busy stays high for exactly 16 edges.
   task automatic run_clear(input string tag);
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         check({tag, "_busy"}, 8'(busy), (k < 16) ? 8'h01 : 8'h00);
         check({tag, "_rv"}, 8'(rvalid), 8'h00);
      end
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; waddr = '0; wmask = '0; din = '0; re = 1'b0; raddr = '0;
      #2;
      check("rst_busy", 8'(busy), 8'h01);
      check("rst_dout", dout, 8'h00);
      check("rst_rv", 8'(rvalid), 8'h00);
      tick();
      tick();
      #2;

      // Requests during busy must be ignored.
      we = 1'b1; waddr = 4'd2; din = 8'hFF; wmask = 8'hFF;
      re = 1'b1; raddr = 4'd2;
      run_clear("clr1");
      we = 1'b0; re = 1'b0;

      // Back-to-back sweep of all addresses, one word per cycle.
      for (int i = 0; i < 18; i++) begin
         if (i < 16) begin
            re = 1'b1; raddr = 4'(i);
         end else begin
            re = 1'b0;
         end
         tick();
         if (i == 0 || i == 17) begin
            check("sweep_rv_idle", 8'(rvalid), 8'h00);
         end else begin
            check("sweep_rv", 8'(rvalid), 8'h01);
            check("sweep_dout", dout, 8'h00);
         end
      end

      do_write(4'd3, 8'hA5, 8'hFF);
      do_write(4'd3, 8'hFF, 8'h0F);
      do_read("partial", 4'd3, 8'hAF);

      // Same-address read-during-write, full mask.
      we = 1'b1; waddr = 4'd5; din = 8'h3C; wmask = 8'hFF;
      re = 1'b1; raddr = 4'd5;
      tick();
      we = 1'b0; re = 1'b0;
      tick();
      check("rdw_rv", 8'(rvalid), 8'h01);
      check("rdw_dout", dout, 8'h3C);

      // Same-address read-during-write, partial mask: (AF & 0F) | (50 & F0) = 5F.
      we = 1'b1; waddr = 4'd3; din = 8'h50; wmask = 8'hF0;
      re = 1'b1; raddr = 4'd3;
      tick();
      we = 1'b0; re = 1'b0;
      tick();
      check("rdw_part", dout, 8'h5F);

      do_write(4'd3, 8'h00, 8'h00);
      do_read("mask0", 4'd3, 8'h5F);

      // Different addresses in the same cycle do not interact.
      we = 1'b1; waddr = 4'd6; din = 8'h77; wmask = 8'hFF;
      re = 1'b1; raddr = 4'd5;
      tick();
      we = 1'b0; re = 1'b0;
      tick();
      check("diff_dout", dout, 8'h3C);
      do_read("diff_wr", 4'd6, 8'h77);

      // Write after read launch does not disturb the in-flight read.
      do_write(4'd7, 8'h11, 8'hFF);
      re = 1'b1; raddr = 4'd7;
      tick();
      re = 1'b0;
      we = 1'b1; waddr = 4'd7; din = 8'h22; wmask = 8'hFF;
      tick();
      we = 1'b0;
      check("war_rv", 8'(rvalid), 8'h01);
      check("war_dout", dout, 8'h11);
      tick();
      do_read("war_new", 4'd7, 8'h22);

      // Reset with a read in stage 1.
      re = 1'b1; raddr = 4'd7;
      tick();
      re = 1'b0;
      rst = 1'b1;
      #1;
      check("rrd_busy", 8'(busy), 8'h01);
      check("rrd_rv", 8'(rvalid), 8'h00);
      check("rrd_dout", dout, 8'h00);
      tick();
      check("rrd_rv2", 8'(rvalid), 8'h00);

      // Release, then reset again once the clear pointer reaches address 9.
      rst = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         check("mid_busy", 8'(busy), 8'h01);
      end
      rst = 1'b1;
      #1;
      check("mid_rst_busy", 8'(busy), 8'h01);
      tick();
      run_clear("clr2");

      do_read("clr_a3", 4'd3, 8'h00);
      do_read("clr_a7", 4'd7, 8'h00);
      do_read("clr_a15", 4'd15, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/masked_dp_ram.md
# masked_dp_ram

Parametrised simple-dual-port RAM with a per-bit write mask, a two-stage registered read pipeline with a valid flag, and a hardware clear sequencer run after every reset. Replaces the fixed 16x8 lab RAM with its hardwired 2-bit partial write. It is the storage primitive for display buffers and lookup memories in the experiment top levels. Independent write and read ports may both be used in the same cycle.

## Interface
- DATA_W, 8, word width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- CLEAR_VAL, 0, DATA_W-bit value written to every word by the clear sequencer
- clk  in  1  single clock, rising-edge active
- rst  in  1  asynchronous, active-high reset
- we  in  1  write request
- waddr  in  ADDR_W  write address
- wmask  in  DATA_W  per-bit write enable; bit i = 1 writes din[i]
- din  in  DATA_W  write data
- re  in  1  read request
- raddr  in  ADDR_W  read address
- dout  out  DATA_W  read data, held until the next valid read
- rvalid  out  1  one-cycle pulse: dout updated this cycle
- busy  out  1  clear sequence in progress; all requests ignored

## Operation
- States: CLEAR, RUN.
- rst asserted: state goes to CLEAR and clear pointer goes to 0. busy=1, dout=0, rvalid=0, and both pipeline stages are invalidated.
- Array contents are not reset asynchronously. The sequencer rewrites them.
- CLEAR: each rising edge writes CLEAR_VAL to mem[ptr] and increments ptr. On the edge that writes mem[DEPTH-1], the block enters RUN and busy goes to 0.
- CLEAR: we and re are ignored. No write occurs, no read is launched, and rvalid stays 0.
- RUN write: at an edge with we=1, mem[waddr] becomes (mem[waddr] & ~wmask) | (din & wmask).
- wmask=0 with we=1 is legal and leaves the word unchanged. wmask all-ones is a full-word write.
- RUN read: at an edge with re=1, stage 1 captures the word at raddr and its valid bit. At the next edge, stage 2 loads dout and asserts rvalid.
- A stage-1 valid bit of 0 leaves dout unchanged and drives rvalid to 0.
- Read-during-write to the same address in the same cycle is write-first. Stage 1 captures the merged value (old & ~wmask) | (din & wmask).
- Read-during-write to different addresses has no interaction.
- A write on the cycle after a read launch does not alter that read's result. The word was already captured in stage 1.
- Back-to-back reads are allowed every cycle, giving a throughput of 1 word/cycle.
- Addresses wrap naturally at ADDR_W bits. There are no out-of-range cases.

## Timing
- Read latency is 2 edges. re is sampled at edge t, and dout/rvalid become valid after edge t+1.
- rvalid is high for exactly one cycle per accepted read. It stays low on cycles with no read in stage 1.
- Clear duration: rst falls before edge 1. Edges 1..DEPTH write addresses 0..DEPTH-1, and busy=0 after edge DEPTH.
- The first request is accepted at edge DEPTH+1.
- Reset mid-clear or mid-read: the asynchronous return takes effect immediately. In-flight reads are discarded with no rvalid, and the clear restarts from address 0.
- Outputs after reset: dout=0, rvalid=0, busy=1.

## Test plan
- Reset, then release with defaults (8/4/0). busy must stay high for exactly 16 edges. Reading all 16 addresses must return 0x00 each, with rvalid pulses 2 edges after each re.
- Full write 0xA5 to addr 3, then partial write din=0xFF, wmask=0x0F to addr 3. A read of addr 3 must return 0xAF.
- Same-cycle we=1, waddr=5, din=0x3C, wmask=0xFF and re=1, raddr=5, with old value 0x00. dout must be 0x3C two edges later.
- Read addr 7 (holding 0x11) at edge t, then write 0x22 to addr 7 at edge t+1. dout must be 0x11 after edge t+1, and a later read must return 0x22.
- Assert rst while a read is in stage 1 and during clear address 9. rvalid must stay 0, busy must go to 1 immediately, and after release the full 16-edge clear must rerun.
- Assert we/re during busy with waddr=2, din=0xFF. After the clear, addr 2 must read CLEAR_VAL, and no rvalid may appear during busy.
